// File: rtl/ux607_plic_gateway_vec_if.sv
// Gateway-side bundle for the PLIC slice: raw sources and modes, claim/complete strobes,
// and the pending-register write port plus in-flight status.
interface ux607_plic_gateway_vec_if #(
  parameter int N    = 3,
  parameter int ID_W = 2
);
  logic [N-1:0]    io_src;
  logic [N-1:0]    io_edge;
  logic            io_claim;
  logic [ID_W-1:0] io_claim_id;
  logic            io_complete;
  logic [ID_W-1:0] io_complete_id;
  logic [N-1:0]    io_pend_d;
  logic            io_pend_en;
  logic [N-1:0]    io_inflight;

  modport master (
    output io_src, io_edge, io_claim, io_claim_id, io_complete, io_complete_id,
    input  io_pend_d, io_pend_en, io_inflight
  );

  modport slave (
    input  io_src, io_edge, io_claim, io_claim_id, io_complete, io_complete_id,
    output io_pend_d, io_pend_en, io_inflight
  );
endinterface

// File: rtl/ux607_plic_gateway_vec.sv
// Per-source PLIC interrupt gateway: turns level/edge sources into single pending requests,
// holds a source off while claimed, and counts edges that arrive while a request is outstanding.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no request outstanding for this source
// ST_PEND   | request sitting in the pending register, not yet claimed
// ST_FLIGHT | claimed by a hart, waiting for the completion strobe
module ux607_plic_gateway_vec #(
  parameter int N     = 3,
  parameter int CNT_W = 2,
  parameter int ID_W  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  ux607_plic_gateway_vec_if.slave      io
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_FLIGHT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q   [N];
  state_t           state_nxt [N];
  logic [CNT_W-1:0] cnt_q     [N];
  logic [CNT_W-1:0] cnt_nxt   [N];
  logic [N-1:0]     src_q;

  logic [N-1:0]     rise;
  logic [N-1:0]     avail;
  logic [N-1:0]     consume;
  logic [N-1:0]     claim_hit;
  logic [N-1:0]     complete_hit;
  logic [N-1:0]     pend_cur;
  logic [N-1:0]     pend_nxt;

  // State register: FSMs, edge detector history and event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      src_q <= io.io_src;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_nxt[i];
        cnt_q[i]   <= cnt_nxt[i];
      end
    end
  end

  // Next-state logic. Source i answers to PLIC id i+1; id 0 never matches.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rise[i]         = io.io_src[i] & ~src_q[i];
      avail[i]        = rise[i] | (cnt_q[i] != '0);
      claim_hit[i]    = io.io_claim    && (io.io_claim_id    == ID_W'(i + 1));
      complete_hit[i] = io.io_complete && (io.io_complete_id == ID_W'(i + 1));
      state_nxt[i]    = state_q[i];
      consume[i]      = 1'b0;

      case (state_q[i])
        ST_IDLE: begin
          if (io.io_edge[i]) begin
            if (avail[i]) begin
              state_nxt[i] = ST_PEND;
              consume[i]   = 1'b1;
            end
          end else if (io.io_src[i]) begin
            state_nxt[i] = ST_PEND;
          end
        end
        ST_PEND: begin
          if (claim_hit[i]) state_nxt[i] = ST_FLIGHT;
        end
        ST_FLIGHT: begin
          if (complete_hit[i]) begin
            if (io.io_edge[i]) begin
              if (avail[i]) begin
                state_nxt[i] = ST_PEND;
                consume[i]   = 1'b1;
              end else begin
                state_nxt[i] = ST_IDLE;
              end
            end else begin
              state_nxt[i] = io.io_src[i] ? ST_PEND : ST_IDLE;
            end
          end
        end
        default: state_nxt[i] = ST_IDLE;
      endcase

      // A rise that is itself consumed leaves the count alone; a stored event is used
      // only when no fresh rise is available.
      cnt_nxt[i] = cnt_q[i];
      if (!io.io_edge[i]) begin
        cnt_nxt[i] = '0;
      end else if (consume[i] && !rise[i]) begin
        cnt_nxt[i] = cnt_q[i] - CNT_ONE;
      end else if (rise[i] && !consume[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_nxt[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Outputs. The pending register loads on the same edge as the FSMs, so its q always
  // mirrors the PEND bits; reset forces a clearing write.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pend_cur[i]       = (state_q[i]   == ST_PEND);
      pend_nxt[i]       = (state_nxt[i] == ST_PEND);
      io.io_inflight[i] = (state_q[i]   == ST_FLIGHT);
    end
    io.io_pend_d  = reset ? '0 : pend_nxt;
    io.io_pend_en = reset | (pend_nxt != pend_cur);
  end

endmodule

// File: tb/tb_ux607_plic_gateway_vec.sv
// Directed bench for the PLIC gateway: expected pending/in-flight values are queued as each
// step is driven and popped as the DUT responds.
module tb_ux607_plic_gateway_vec;

  logic clock;
  logic reset;

  ux607_plic_gateway_vec_if #(.N(3), .ID_W(2)) bus ();

  ux607_plic_gateway_vec #(.N(3), .CNT_W(2), .ID_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  typedef struct packed {
    logic [2:0] d;
    logic       en;
    logic [2:0] inf;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock of stimulus: comb outputs checked mid-cycle, in-flight checked after the edge.
  task automatic step(input string tag, input logic rst, input logic [2:0] src,
                      input logic claim, input logic [1:0] cid,
                      input logic comp, input logic [1:0] compid,
                      input logic [2:0] exp_d, input logic exp_en, input logic [2:0] exp_inf);
    exp_t e;
    exp_t f;
    e.d = exp_d; e.en = exp_en; e.inf = exp_inf;
    sb.push_back(e);
    @(negedge clock);
    reset              = rst;
    bus.io_src         = src;
    bus.io_claim       = claim;
    bus.io_claim_id    = cid;
    bus.io_complete    = comp;
    bus.io_complete_id = compid;
    #2;
    f = sb[0];
    n_total++;
    assert (bus.io_pend_d === f.d) n_pass++;
    else $error("FAIL %s pend_d: got %b want %b", tag, bus.io_pend_d, f.d);
    n_total++;
    assert (bus.io_pend_en === f.en) n_pass++;
    else $error("FAIL %s pend_en: got %b want %b", tag, bus.io_pend_en, f.en);
    @(posedge clock);
    #1;
    f = sb.pop_front();
    n_total++;
    assert (bus.io_inflight === f.inf) n_pass++;
    else $error("FAIL %s inflight: got %b want %b", tag, bus.io_inflight, f.inf);
  endtask

  initial begin
    reset              = 1'b1;
    bus.io_src         = '0;
    bus.io_edge        = 3'b010;   // source 1 edge-triggered, sources 0 and 2 level
    bus.io_claim       = 1'b0;
    bus.io_claim_id    = '0;
    bus.io_complete    = 1'b0;
    bus.io_complete_id = '0;

    //    tag            rst src    clm id   cmp id    pend_d en  inflight
    step("reset0",       1, 3'b000, 0, 2'd0, 0, 2'd0, 3'b000, 1, 3'b000);
    step("reset1",       1, 3'b000, 0, 2'd0, 0, 2'd0, 3'b000, 1, 3'b000);
    step("idle",         0, 3'b000, 0, 2'd0, 0, 2'd0, 3'b000, 0, 3'b000);

    // Level source 0
    step("lvl_rise",     0, 3'b001, 0, 2'd0, 0, 2'd0, 3'b001, 1, 3'b000);
    step("lvl_no_retr",  0, 3'b000, 0, 2'd0, 0, 2'd0, 3'b001, 0, 3'b000);
    step("lvl_claim",    0, 3'b000, 1, 2'd1, 0, 2'd0, 3'b000, 1, 3'b001);
    step("lvl_cmpl_hi",  0, 3'b001, 0, 2'd0, 1, 2'd1, 3'b001, 1, 3'b000);
    step("lvl_claim2",   0, 3'b000, 1, 2'd1, 0, 2'd0, 3'b000, 1, 3'b001);
    step("lvl_cmpl_lo",  0, 3'b000, 0, 2'd0, 1, 2'd1, 3'b000, 0, 3'b000);

    // Edge source 1: four pulses while in flight saturate the counter at 3
    step("edg_rise",     0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b010, 1, 3'b000);
    step("edg_hold",     0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b010, 0, 3'b000);
    step("edg_claim",    0, 3'b000, 1, 2'd2, 0, 2'd0, 3'b000, 1, 3'b010);
    for (int i = 0; i < 8; i++)
      step("edg_pulse",  0, (i % 2 == 0) ? 3'b010 : 3'b000, 0, 2'd0, 0, 2'd0, 3'b000, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      step("edg_repend", 0, 3'b000, 0, 2'd0, 1, 2'd2, 3'b010, 1, 3'b000);
      step("edg_reclaim",0, 3'b000, 1, 2'd2, 0, 2'd0, 3'b000, 1, 3'b010);
    end
    step("edg_drained",  0, 3'b000, 0, 2'd0, 1, 2'd2, 3'b000, 0, 3'b000);

    // Rise coinciding with completion, counter empty: re-pend and count stays 0
    step("rc_rise",      0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b010, 1, 3'b000);
    step("rc_claim",     0, 3'b000, 1, 2'd2, 0, 2'd0, 3'b000, 1, 3'b010);
    step("rc_cmpl_rise", 0, 3'b010, 0, 2'd0, 1, 2'd2, 3'b010, 1, 3'b000);
    step("rc_claim2",    0, 3'b010, 1, 2'd2, 0, 2'd0, 3'b000, 1, 3'b010);
    step("rc_cnt_zero",  0, 3'b000, 0, 2'd0, 1, 2'd2, 3'b000, 0, 3'b000);

    // Strobes that must be ignored
    step("ign_setup",    0, 3'b001, 0, 2'd0, 0, 2'd0, 3'b001, 1, 3'b000);
    step("ign_claim0",   0, 3'b000, 1, 2'd0, 0, 2'd0, 3'b001, 0, 3'b000);
    step("ign_claim_id", 0, 3'b000, 1, 2'd3, 0, 2'd0, 3'b001, 0, 3'b000);
    step("ign_cmpl_pnd", 0, 3'b000, 0, 2'd0, 1, 2'd1, 3'b001, 0, 3'b000);

    // Claim and complete of different sources in the same cycle
    step("dual_setup",   0, 3'b100, 0, 2'd0, 0, 2'd0, 3'b101, 1, 3'b000);
    step("dual_claim3",  0, 3'b000, 1, 2'd3, 0, 2'd0, 3'b001, 1, 3'b100);
    step("dual_both",    0, 3'b100, 1, 2'd1, 1, 2'd3, 3'b100, 1, 3'b001);

    // Reset mid-operation with a non-zero edge count, source held high through release
    step("rst_pre_rise", 0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b110, 1, 3'b001);
    step("rst_pre_low",  0, 3'b000, 0, 2'd0, 0, 2'd0, 3'b110, 0, 3'b001);
    step("rst_pre_cnt",  0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b110, 0, 3'b001);
    step("rst_mid0",     1, 3'b010, 0, 2'd0, 0, 2'd0, 3'b000, 1, 3'b000);
    step("rst_mid1",     1, 3'b010, 0, 2'd0, 0, 2'd0, 3'b000, 1, 3'b000);
    step("rst_rel_rise", 0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b010, 1, 3'b000);
    step("rst_rel_hold", 0, 3'b010, 0, 2'd0, 0, 2'd0, 3'b010, 0, 3'b000);
    step("rst_claim",    0, 3'b000, 1, 2'd2, 0, 2'd0, 3'b000, 1, 3'b010);
    step("rst_cnt_gone", 0, 3'b000, 0, 2'd0, 1, 2'd2, 3'b000, 0, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
